// File: rtl/rot_enc_cnt_pkg.sv
// rot_enc_cnt_pkg: detent FSM states, idle pin level and per-state expected A/B pattern
package rot_enc_cnt_pkg;
   typedef enum logic [2:0] {DET, CW1, CW2, CW3, CC1, CC2, CC3} rot_state_t;
   localparam logic IDLE = 1'b1;
   function automatic logic [1:0] state_pat(rot_state_t s);
      return s == DET ? 2'b11 :
             (s == CW1 || s == CC3) ? 2'b01 :
             (s == CW2 || s == CC2) ? 2'b00 : 2'b10;
   endfunction
endpackage

// File: rtl/rot_debounce.sv
// rot_debounce: two-flop synchroniser plus stability filter, idles high out of reset
module rot_debounce
   import rot_enc_cnt_pkg::*;
#(
   parameter int DEB_CYCLES = 20000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic IN,
   output logic OUT
);
   localparam int CNT_W = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   logic s1, s2;
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         s1  <= IDLE;
         s2  <= IDLE;
         OUT <= IDLE;
         cnt <= '0;
      end else begin
         s1 <= IN;
         s2 <= s1;
         if (s2 == OUT) cnt <= '0;
         else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            OUT <= s2;
            cnt <= '0;
         end else cnt <= cnt + CNT_W'(1);
      end
endmodule

// File: rtl/rot_enc_cnt.sv
// rot_enc_cnt: debounced quadrature detent decoder driving a 4-bit position count
module rot_enc_cnt
   import rot_enc_cnt_pkg::*;
#(
   parameter int DEB_CYCLES = 20000,
   parameter int MAX_VAL    = 15,
   parameter bit WRAP       = 1'b1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic ENC_A,
   input  logic ENC_B,
   input  logic ENC_SW,
   output logic R3,
   output logic R2,
   output logic R1,
   output logic R0,
   output logic STEP,
   output logic DIR,
   output logic ERR
);
   localparam logic [3:0] MAX = 4'(MAX_VAL);
   logic a_f, b_f, sw_f, up, dn;
   logic [1:0] ab, ab_q, pat;
   logic [3:0] cnt, cnt_nx;
   rot_state_t st, st_nx;
   rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_a  (.CLK, .RST_N, .IN(ENC_A),  .OUT(a_f));
   rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_b  (.CLK, .RST_N, .IN(ENC_B),  .OUT(b_f));
   rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw (.CLK, .RST_N, .IN(ENC_SW), .OUT(sw_f));
   assign ab = {a_f, b_f};
   assign {R3, R2, R1, R0} = cnt;
   // Only single-bit moves away from the state pattern advance the FSM
   always_comb begin
      pat   = state_pat(st);
      st_nx = st;
      up    = 1'b0;
      dn    = 1'b0;
      if (ab != pat && ab != ~pat)
         case (st)
            DET: st_nx = ab == 2'b01 ? CW1 : CC1;
            CW1: st_nx = ab == 2'b00 ? CW2 : DET;
            CW2: st_nx = ab == 2'b10 ? CW3 : CW1;
            CW3: begin
               st_nx = ab == 2'b11 ? DET : CW2;
               up    = ab == 2'b11;
            end
            CC1: st_nx = ab == 2'b00 ? CC2 : DET;
            CC2: st_nx = ab == 2'b01 ? CC3 : CC1;
            CC3: begin
               st_nx = ab == 2'b11 ? DET : CC2;
               dn    = ab == 2'b11;
            end
            default: st_nx = DET;
         endcase
      cnt_nx = !sw_f ? 4'd0 :
               up ? (cnt == MAX ? (WRAP ? 4'd0 : MAX) : cnt + 4'd1) :
               dn ? (cnt == 4'd0 ? (WRAP ? MAX : 4'd0) : cnt - 4'd1) : cnt;
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         st   <= DET;
         cnt  <= 4'd0;
         ab_q <= {IDLE, IDLE};
         STEP <= 1'b0;
         DIR  <= 1'b0;
         ERR  <= 1'b0;
      end else begin
         st   <= st_nx;
         cnt  <= cnt_nx;
         ab_q <= ab;
         STEP <= cnt_nx != cnt;
         if (cnt_nx != cnt && sw_f) DIR <= up;
         // Report an illegal jump once, when it appears, not while it persists
         ERR  <= ab == ~pat && ab != ab_q;
      end
endmodule

// File: tb/tb_rot_enc_cnt.sv
// tb_rot_enc_cnt: directed plus random encoder traffic against a displacement-based reference model
module tb_rot_enc_cnt;
   localparam int DEB = 4;
   logic clk = 1'b0, rst_n = 1'b0, enc_a = 1'b1, enc_b = 1'b1, enc_sw = 1'b1;
   logic w3, w2, w1, w0, w_step, w_dir, w_err;
   logic s3, s2, s1, s0, s_step, s_dir, s_err;
   int checks = 0, failures = 0;
   int nst_w = 0, nst_s = 0, nerr = 0;
   int d;
   logic fa, fb, fs, eerr;
   logic [1:0] fab_q;
   logic q_a[$], q_b[$], q_s[$];
   logic [3:0] ecnt[2], mx[2];
   logic estep[2], edir[2], wr[2];

   always #5 clk = ~clk;

   rot_enc_cnt #(.DEB_CYCLES(DEB), .MAX_VAL(15), .WRAP(1'b1)) dut_w (
      .CLK(clk), .RST_N(rst_n), .ENC_A(enc_a), .ENC_B(enc_b), .ENC_SW(enc_sw),
      .R3(w3), .R2(w2), .R1(w1), .R0(w0), .STEP(w_step), .DIR(w_dir), .ERR(w_err));
   rot_enc_cnt #(.DEB_CYCLES(DEB), .MAX_VAL(9), .WRAP(1'b0)) dut_s (
      .CLK(clk), .RST_N(rst_n), .ENC_A(enc_a), .ENC_B(enc_b), .ENC_SW(enc_sw),
      .R3(s3), .R2(s2), .R1(s1), .R0(s0), .STEP(s_step), .DIR(s_dir), .ERR(s_err));

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      d = 0; fa = 1'b1; fb = 1'b1; fs = 1'b1; fab_q = 2'b11; eerr = 1'b0;
      q_a = {}; q_b = {}; q_s = {};
      for (int j = 0; j < DEB + 2; j++) begin
         q_a.push_back(1'b1); q_b.push_back(1'b1); q_s.push_back(1'b1);
      end
      for (int i = 0; i < 2; i++) begin
         ecnt[i] = 4'd0; estep[i] = 1'b0; edir[i] = 1'b0;
      end
   endtask

   // Filtered level flips once the DEB synchronised samples before it all disagree with it
   function automatic logic settle(input logic q[$], input logic f);
      int n;
      n = q.size();
      for (int j = 3; j <= DEB + 2; j++) if (q[n-j] == f) return f;
      return ~f;
   endfunction

   task automatic model_edge();
      int p, dl, dc;
      logic [1:0] ab;
      logic [3:0] nc;
      ab = {fa, fb};
      p  = ab == 2'b11 ? 0 : ab == 2'b01 ? 1 : ab == 2'b00 ? 2 : 3;
      dl = ((p - d) % 4 + 4) % 4;
      eerr = dl == 2 && ab != fab_q;
      dc = 0;
      if (dl == 1) d++;
      else if (dl == 3) d--;
      if (d == 4) begin d = 0; dc = 1; end
      else if (d == -4) begin d = 0; dc = -1; end
      for (int i = 0; i < 2; i++) begin
         nc = ecnt[i];
         if (dc == 1) nc = ecnt[i] == mx[i] ? (wr[i] ? 4'd0 : mx[i]) : ecnt[i] + 4'd1;
         if (dc == -1) nc = ecnt[i] == 4'd0 ? (wr[i] ? mx[i] : 4'd0) : ecnt[i] - 4'd1;
         if (!fs) nc = 4'd0;
         estep[i] = nc != ecnt[i];
         if (estep[i] && fs) edir[i] = dc == 1;
         ecnt[i] = nc;
      end
      fab_q = ab;
      q_a.push_back(enc_a); q_b.push_back(enc_b); q_s.push_back(enc_sw);
      fa = settle(q_a, fa); fb = settle(q_b, fb); fs = settle(q_s, fs);
      if (q_a.size() > 16) begin void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_s.pop_front()); end
   endtask

   initial begin
      mx[0] = 4'd15; mx[1] = 4'd9; wr[0] = 1'b1; wr[1] = 1'b0;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_edge();
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check("wrap_outputs", {w3, w2, w1, w0, w_step, w_dir, w_err}, {ecnt[0], estep[0], edir[0], eerr});
         check("sat_outputs", {s3, s2, s1, s0, s_step, s_dir, s_err}, {ecnt[1], estep[1], edir[1], eerr});
         if (w_step) nst_w++;
         if (s_step) nst_s++;
         if (w_err) nerr++;
      end
   end

   task automatic hold(input logic [1:0] ab, input int n);
      {enc_a, enc_b} = ab;
      repeat (n) @(negedge clk);
   endtask
   task automatic cw();
      hold(2'b01, 10); hold(2'b00, 10); hold(2'b10, 10); hold(2'b11, 10);
   endtask
   task automatic ccw();
      hold(2'b10, 10); hold(2'b00, 10); hold(2'b01, 10); hold(2'b11, 10);
   endtask
   task automatic press(input int n);
      enc_sw = 1'b0;
      repeat (n) @(negedge clk);
      enc_sw = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      int lat, base;
      repeat (3) @(negedge clk);
      check("reset_wrap", {w3, w2, w1, w0, w_step, w_dir, w_err}, 0);
      check("reset_sat", {s3, s2, s1, s0, s_step, s_dir, s_err}, 0);
      rst_n = 1'b1;
      hold(2'b01, 10); hold(2'b00, 10); hold(2'b10, 10);
      {enc_a, enc_b} = 2'b11;
      lat = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(negedge clk);
         if (w_step) lat = n;
      end
      check("cw_latency", lat, 7);
      check("cw_count", {w3, w2, w1, w0}, 1);
      check("cw_dir", w_dir, 1);
      repeat (5) @(negedge clk);
      press(10);
      check("clear_count", {w3, w2, w1, w0}, 0);
      ccw();
      check("ccw_wrap", {w3, w2, w1, w0}, 15);
      check("ccw_dir", w_dir, 0);
      check("ccw_sat_floor", {s3, s2, s1, s0}, 0);
      cw();
      check("cw_wrap", {w3, w2, w1, w0}, 0);
      base = nerr;
      hold(2'b01, 10);
      repeat (5) begin
         enc_a = 1'b1; repeat (2) @(negedge clk);
         enc_a = 1'b0; repeat (2) @(negedge clk);
      end
      hold(2'b01, 10); hold(2'b00, 10); hold(2'b10, 10); hold(2'b11, 10);
      check("bounce_count", {w3, w2, w1, w0}, 1);
      check("bounce_no_err", nerr - base, 0);
      base = nst_w;
      hold(2'b01, 10); hold(2'b00, 10); hold(2'b01, 10); hold(2'b11, 10);
      check("backtrack_count", {w3, w2, w1, w0}, 1);
      check("backtrack_steps", nst_w - base, 0);
      base = nerr;
      hold(2'b00, 10); hold(2'b10, 10); hold(2'b11, 10);
      check("illegal_err", nerr - base, 1);
      check("illegal_count", {w3, w2, w1, w0}, 1);
      press(10);
      repeat (9) cw();
      check("sat_nine", {s3, s2, s1, s0}, 9);
      base = nst_s;
      cw();
      check("sat_hold", {s3, s2, s1, s0}, 9);
      check("sat_no_step", nst_s - base, 0);
      check("wrap_ten", {w3, w2, w1, w0}, 10);
      base = nst_s;
      press(10);
      check("sat_clear", {s3, s2, s1, s0}, 0);
      check("sat_clear_step", nst_s - base, 1);
      enc_sw = 1'b0;
      cw();
      check("clear_wins", {s3, s2, s1, s0, w3, w2, w1, w0}, 0);
      enc_sw = 1'b1;
      repeat (10) @(negedge clk);
      repeat (5) cw();
      hold(2'b01, 10); hold(2'b00, 10);
      check("pre_reset_count", {w3, w2, w1, w0}, 5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_wrap", {w3, w2, w1, w0, w_step, w_dir, w_err}, 0);
      check("async_reset_sat", {s3, s2, s1, s0, s_step, s_dir, s_err}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold(2'b00, 10); hold(2'b10, 10); hold(2'b11, 10);
      check("post_reset_count", {w3, w2, w1, w0, s3, s2, s1, s0}, 0);
      repeat (150) begin
         case ($urandom_range(0, 5))
            0: cw();
            1: ccw();
            2: begin hold(2'b10, 10); hold(2'b00, 10); hold(2'b10, 10); hold(2'b11, 10); end
            3: hold(2'($urandom), $urandom_range(1, 12));
            4: press($urandom_range(1, 8));
            default: begin
               enc_b = ~enc_b;
               repeat ($urandom_range(1, 3)) @(negedge clk);
               enc_b = ~enc_b;
               repeat (8) @(negedge clk);
            end
         endcase
      end
      hold(2'b11, 20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
